// File: rtl/slt_iter_pkg.sv
// slt_iter_pkg: shared state encodings and mode constants for the iterative set-less-than unit
package slt_iter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic MODE_SIGNED   = 1'b0;
    localparam logic MODE_UNSIGNED = 1'b1;

endpackage

// File: rtl/slt_iter_digit_cmp.sv
// slt_iter_digit_cmp: combinational unsigned compare of one DIGIT-wide slice
module slt_iter_digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             lt,
    output logic             ne
);

    assign lt = x < y;
    assign ne = x != y;

endmodule

// File: rtl/slt_iter.sv
// slt_iter: multi-cycle SLT/SLTU, scans DIGIT bits per cycle from the MSB with early exit
module slt_iter
    import slt_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_unsigned,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             lt,
    output logic             eq
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = NDIG > 1 ? $clog2(NDIG) : 1;

    logic [0:0]       state;
    logic [WIDTH-1:0] ra, rb;
    logic [IW-1:0]    idx;
    logic [DIGIT-1:0] xd, yd;
    logic             dlt, dne;

    assign xd   = ra[idx*DIGIT +: DIGIT];
    assign yd   = rb[idx*DIGIT +: DIGIT];
    assign busy = state == ST_SCAN;

    slt_iter_digit_cmp #(.DIGIT(DIGIT)) u_cmp (
        .x  (xd),
        .y  (yd),
        .lt (dlt),
        .ne (dne)
    );

    // FSM: latch biased operands on start, then walk digits down until a difference or digit 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ra     <= '0;
            rb     <= '0;
            idx    <= '0;
            done   <= 1'b0;
            result <= '0;
            lt     <= 1'b0;
            eq     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    ra    <= is_unsigned == MODE_UNSIGNED ? a : {~a[WIDTH-1], a[WIDTH-2:0]};
                    rb    <= is_unsigned == MODE_UNSIGNED ? b : {~b[WIDTH-1], b[WIDTH-2:0]};
                    idx   <= IW'(NDIG - 1);
                    state <= ST_SCAN;
                end
            end else if (dne || idx == '0) begin
                lt     <= dlt;
                eq     <= ~dne;
                result <= WIDTH'(dlt);
                done   <= 1'b1;
                state  <= ST_IDLE;
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule
